// File: rtl/mem_port_arbiter.sv
// Shares one registered-read memory port between the instruction fetch
// unit (IFU, read-only) and the data unit (DAT, read/write).
//
// Ports:
//   clk, rst                         clock, sync active-high reset
//   ifu_rd_req/addr -> ifu_rd_data   IFU read request, data, ack pulse
//   dat_req/we/addr/wr_data          DAT request, rd data, ack pulse
//   mem_rd_req/wr_req/addr/wr_data   memory strobes, address, write data
//   mem_rd_data                      memory data, valid cycle after strobe
//   busy                             high whenever not IDLE
//
// One access takes four cycles: IDLE -> ISSUE -> RESP -> ACK.
// DAT wins contests until IFU has lost MAX_STARVE in a row.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int MAX_STARVE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  ifu_ack,
  input  logic                  dat_req,
  input  logic                  dat_we,
  input  logic [ADDR_WIDTH-1:0] dat_addr,
  input  logic [DATA_WIDTH-1:0] dat_wr_data,
  output logic [DATA_WIDTH-1:0] dat_rd_data,
  output logic                  dat_ack,
  output logic                  mem_rd_req,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy
);

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP,
    S_ACK
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_own_ifu;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_ifu_rd;
  logic [DATA_WIDTH-1:0] r_dat_rd;
  logic [SW-1:0]         r_starve;

  logic w_any_req;
  logic w_contest;
  logic w_gnt_ifu;

  assign w_any_req = ifu_rd_req | dat_req;
  assign w_contest = ifu_rd_req & dat_req;
  // IFU wins when alone, or when it has lost too many contests in a row.
  assign w_gnt_ifu = ifu_rd_req &
                     (~dat_req | (r_starve == STARVE_MAX));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_ISSUE;
      S_ISSUE: w_next = S_RESP;
      S_RESP:  w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, starvation counter and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_own_ifu <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ifu_rd  <= '0;
      r_dat_rd  <= '0;
      r_starve  <= '0;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        r_own_ifu <= w_gnt_ifu;
        if (w_gnt_ifu) begin
          r_we     <= 1'b0;
          r_addr   <= ifu_rd_addr;
          r_starve <= '0;
        end else begin
          r_we    <= dat_we;
          r_addr  <= dat_addr;
          r_wdata <= dat_wr_data;
          // A contested DAT win implies r_starve is below the limit.
          if (w_contest) r_starve <= r_starve + 1'b1;
        end
      end
      if (r_state == S_RESP && !r_we) begin
        if (r_own_ifu) r_ifu_rd <= mem_rd_data;
        else           r_dat_rd <= mem_rd_data;
      end
    end
  end

  // Output logic
  always_comb begin
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    ifu_ack    = 1'b0;
    dat_ack    = 1'b0;
    busy       = 1'b1;
    unique case (r_state)
      S_IDLE:  busy = 1'b0;
      S_ISSUE: begin
        mem_rd_req = ~r_we;
        mem_wr_req = r_we;
      end
      S_RESP:  ;
      S_ACK: begin
        ifu_ack = r_own_ifu;
        dat_ack = ~r_own_ifu;
      end
      default: busy = 1'b1;
    endcase
  end

  assign mem_addr    = r_addr;
  assign mem_wr_data = r_wdata;
  assign ifu_rd_data = r_ifu_rd;
  assign dat_rd_data = r_dat_rd;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single fetch/memory port (registered read: data valid the cycle after the request) between two requesters.
  - Instruction fetch unit (IFU): read-only.
  - Execute/data unit (DAT): read or write, for the memory-reference opcodes 0–5.
- DAT has fixed priority. A starvation counter forces an IFU grant after MAX_STARVE consecutive lost contests.
- Sits between the IFU/execute stage and the memory model (random-generating or RAM).

Parameters:
- ADDR_WIDTH, 12, word address width.
- DATA_WIDTH, 12, word width.
- MAX_STARVE, 3, consecutive contested IFU losses before IFU is forced to win (≥1).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- ifu_rd_req  in  1  IFU read request; hold until ifu_ack.
- ifu_rd_addr  in  ADDR_WIDTH  IFU address; stable while ifu_rd_req is high.
- ifu_rd_data  out  DATA_WIDTH  IFU read data; valid when ifu_ack=1.
- ifu_ack  out  1  one-cycle completion pulse to IFU.
- dat_req  in  1  DAT request; hold until dat_ack.
- dat_we  in  1  1 = write, 0 = read; stable with dat_req.
- dat_addr  in  ADDR_WIDTH  DAT address.
- dat_wr_data  in  DATA_WIDTH  DAT write data.
- dat_rd_data  out  DATA_WIDTH  DAT read data; valid when dat_ack=1 after a read.
- dat_ack  out  1  one-cycle completion pulse to DAT.
- mem_rd_req  out  1  memory read strobe.
- mem_wr_req  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wr_data  out  DATA_WIDTH  memory write data.
- mem_rd_data  in  DATA_WIDTH  memory read data; valid the cycle after mem_rd_req.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: state=IDLE; all outputs 0; starve_cnt=0; owner=DAT.
- Reset mid-operation: in-flight access is abandoned and no ack is issued. A write already strobed may have landed in memory.
- State machine (one access per 4 cycles; no pipelining):
  - IDLE: if either request is high, latch owner, address, we and write data, then go to ISSUE. Otherwise stay.
  - ISSUE: for exactly this one cycle, drive mem_addr plus mem_rd_req (read) or mem_wr_req (write). Go to RESP.
  - RESP: on a read, register mem_rd_data into the owner's rd_data register at the end of this cycle. Writes capture nothing. Go to ACK.
  - ACK: assert the owner's ack for this one cycle, then go to IDLE.
- Arbitration happens only in IDLE, never in ACK. Requesters change req/addr on the edge that ends the ACK cycle.
- Arbitration rules:
  - Only one request high: grant it.
  - Both high, starve_cnt < MAX_STARVE: grant DAT, starve_cnt += 1.
  - Both high, starve_cnt == MAX_STARVE: grant IFU.
- starve_cnt clears on any IFU grant and saturates at MAX_STARVE. Uncontested DAT grants leave it unchanged. Width is $clog2(MAX_STARVE+1).
- IFU accesses are always reads; mem_wr_req is never asserted for IFU.
- mem_addr and mem_wr_data hold their latched values after ISSUE. Only the strobes are one-cycle.
- ifu_rd_data/dat_rd_data hold their last captured value until the next read by the same owner. A DAT write does not alter dat_rd_data.
- The two acks are never high together, and never high outside ACK.
- A request dropped before its ack is a protocol violation: the access still completes and acks (no abort).

Test Plan:
- IFU read, latency:
  - Stimulus: reset, then ifu_rd_req=1, addr=0o200 at cycle 0; memory returns 0o7402.
  - Required: mem_rd_req=1, mem_addr=0o200 in cycle 1; ifu_ack=1 with ifu_rd_data=0o7402 in cycle 3; IDLE in cycle 4; busy high in cycles 1–3.
- DAT write:
  - Stimulus: dat_req=1, dat_we=1, addr=0o050, data=0o1234.
  - Required: mem_wr_req=1 in cycle 1 with mem_addr=0o050, mem_wr_data=0o1234; mem_rd_req=0; dat_ack in cycle 3; dat_rd_data unchanged.
- Starvation, MAX_STARVE=3:
  - Stimulus: both requesters held continuously.
  - Required grant order: DAT, DAT, DAT, IFU, DAT, DAT, DAT, IFU. starve_cnt goes 1, 2, 3, 0.
- Simultaneous single request after IFU-only traffic:
  - Stimulus: IFU-only traffic, then both requesters assert in the same IDLE cycle.
  - Required: DAT wins; starve_cnt becomes 1.
- Reset mid-access:
  - Stimulus: assert rst during RESP of an IFU read.
  - Required: next cycle state=IDLE, ifu_ack never pulses, all outputs 0, starve_cnt=0.
- Back-to-back IFU:
  - Stimulus: IFU drives a new address on the edge ending ACK.
  - Required: next ISSUE two cycles later with the new address; no duplicate access to the old address.
